kernel_out_unpacker: RTL
========================

Name: kernel_out_unpacker

Overview:
- Downstream neighbour of the NTT kernel. Consumes the kernel's 128-bit store stream (sw_vld/sw_rdy/sw_dat/sw_lst), where each beat carries two 64-bit coefficients.
- Buffers beats in a small FIFO and serialises them into a 64-bit coefficient stream with a last flag, for the output DMA / stream-out path.
- Checks that each polynomial contains exactly pN_COEF coefficients and flags a length error otherwise.

Parameters:
- pDATA_WIDTH, 128, input beat width (two coefficients).
- pOUT_WIDTH, 64, output coefficient width; pDATA_WIDTH must equal 2*pOUT_WIDTH.
- pFIFO_DEPTH, 4, number of 128-bit entries buffered; power of two, at least 2.
- pN_COEF, 256, expected coefficients per polynomial; even, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- sw_vld  in  1  kernel store beat valid
- sw_rdy  out  1  ready toward kernel
- sw_dat  in  pDATA_WIDTH  beat; [63:0] = first coefficient, [127:64] = second
- sw_lst  in  1  beat is the last of the polynomial
- out_vld  out  1  coefficient valid
- out_rdy  in  1  downstream ready
- out_dat  out  pOUT_WIDTH  coefficient
- out_lst  out  1  last coefficient of the polynomial
- err_len  out  1  sticky polynomial length error
- clr_err  in  1  synchronous clear of err_len
- coef_cnt  out  $clog2(pN_COEF)  index of the current output coefficient within the polynomial

Behaviour:
- Reset (async, rst=1): FIFO empty, wr_ptr = rd_ptr = 0, count = 0, sel = 0, coef_cnt = 0, err_len = 0. Outputs: sw_rdy = 0 while rst is high, then 1; out_vld = 0; out_dat = 0; out_lst = 0. Reset mid-operation discards all buffered beats and any partial polynomial.
- Input handshake: a push happens when sw_vld && sw_rdy. The entry {sw_lst, sw_dat} is written at wr_ptr, and wr_ptr wraps modulo pFIFO_DEPTH.
- sw_rdy = (count != pFIFO_DEPTH). It is combinational from registered count only; there is no same-cycle bypass when full. A pop while full does not raise sw_rdy until the next cycle.
- No fall-through: a beat pushed at edge t appears on out_* during cycle t+1 at the earliest. Minimum latency is 1 cycle.
- out_vld = (count != 0). out_dat = sel ? entry[rd_ptr][127:64] : entry[rd_ptr][63:0].
- out_lst = sel && entry[rd_ptr].lst. The low half never carries last.
- Output handshake (out_vld && out_rdy):
  - sel=0 -> sel becomes 1.
  - sel=1 -> sel becomes 0, entry popped, rd_ptr wraps.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- While out_vld=1 and out_rdy=0, out_dat and out_lst are held stable.
- Serialiser states: IDLE (count=0), LO (sel=0), HI (sel=1).
  - IDLE -> LO on the first push.
  - LO -> HI on handshake.
  - HI -> LO on handshake if count after pop > 0, else IDLE.
- Length check, on each output handshake:
  - If out_lst and coef_cnt != pN_COEF-1: set err_len, coef_cnt becomes 0.
  - If !out_lst and coef_cnt == pN_COEF-1: set err_len, coef_cnt wraps to 0.
  - Otherwise, out_lst resets coef_cnt to 0; non-last increments it.
- err_len is sticky until clr_err. If a set condition and clr_err occur in the same cycle, the set wins.
- Data is passed unmodified; no arithmetic on coefficients.

Decomposition:
- Shared package kernel_pkg: DATA_WIDTH=128, COEF_WIDTH=64, N_COEF=256, and the serialiser state enum {IDLE, LO, HI}.
- One sub-module: kernel_sfifo, a synchronous FIFO with parameters width and depth, ports push/pop/full/empty/count, and registered output. The unpacker holds sel, the length checker and the handshake glue.

Test Plan:
- Single beat sw_dat=128'h0000000000000002_0000000000000001, sw_lst=0, with out_rdy=1 -> out_dat 1 then 2 on consecutive cycles; out_lst=0 both times; coef_cnt goes 0 -> 1 -> 2.
- Full polynomial of 128 beats with coefficients 0..255 and sw_lst on the last beat, out_rdy=1 -> 256 words in order 0..255; out_lst only on word 255; err_len=0; coef_cnt back to 0.
- Hold out_rdy=0 and push 4 beats -> sw_rdy drops to 0 after the 4th push; a 5th sw_vld stalls. Release out_rdy -> sw_rdy reasserts the cycle after the first pop, and no data is lost or reordered.
- Short polynomial: sw_lst on the 3rd beat (6 coefficients) -> err_len=1 after the 6th word handshake. Pulse clr_err -> err_len=0. If clr_err coincides with a new error, err_len stays 1.
- Random out_rdy backpressure (50%) on 2 back-to-back polynomials -> out_dat and out_lst stable while stalled; output matches the input order exactly.
- Assert rst with 2 beats buffered and sel=1 -> out_vld=0 and count=0 immediately. After release, the next beat's low coefficient is output first and coef_cnt=0.

Source files
------------

// File: rtl/kernel_pkg.sv
// Shared constants and serialiser state type for the NTT kernel output path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kernel_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int COEF_WIDTH = 64;
    localparam int N_COEF     = 256;

    // Serialiser position: nothing buffered, low half next, high half next.
    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_LO   = 2'd1,
        SER_HI   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/kernel_sfifo.sv
// Small synchronous FIFO, register storage, read data taken from the head entry.
// Latency: an entry written at edge t is visible on rd_dat during cycle t+1.
// Backpressure: push ignored when full, pop ignored when empty; full/empty from registered count.
module kernel_sfifo #(
    parameter int pWIDTH = 129,
    parameter int pDEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [pWIDTH-1:0]          wr_dat,
    input  logic                       pop,
    output logic [pWIDTH-1:0]          rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(pDEPTH):0]    count
);

    localparam int AW = $clog2(pDEPTH);

    logic [pWIDTH-1:0] mem [pDEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(pDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage write; cleared on reset so the head reads as zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < pDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kernel_out_unpacker.sv
// Buffers 128-bit two-coefficient kernel beats and emits them as 64-bit coefficients, low half first, with length checking.
// Latency: 1 cycle minimum from input push to first output coefficient (no fall-through).
// Backpressure: sw_rdy low while the FIFO is full (no same-cycle bypass); output held stable while out_rdy is low.
module kernel_out_unpacker
    import kernel_pkg::*;
#(
    parameter int pDATA_WIDTH = DATA_WIDTH,
    parameter int pOUT_WIDTH  = COEF_WIDTH,
    parameter int pFIFO_DEPTH = 4,
    parameter int pN_COEF     = N_COEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sw_vld,
    output logic                        sw_rdy,
    input  logic [pDATA_WIDTH-1:0]      sw_dat,
    input  logic                        sw_lst,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [pOUT_WIDTH-1:0]       out_dat,
    output logic                        out_lst,
    output logic                        err_len,
    input  logic                        clr_err,
    output logic [$clog2(pN_COEF)-1:0]  coef_cnt
);

    localparam int CW   = $clog2(pN_COEF);
    localparam int CNTW = $clog2(pFIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(pN_COEF - 1);

    logic [pDATA_WIDTH:0] fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNTW-1:0]      fifo_cnt;
    logic                 push;
    logic                 pop;
    logic                 hs;
    logic                 sel;
    logic                 len_bad;
    ser_state_t           state;

    // Ready depends only on registered occupancy, and is forced low during reset.
    assign sw_rdy  = !rst && !fifo_full;
    assign push    = sw_vld && sw_rdy;
    assign out_vld = !fifo_empty;
    assign sel     = (state == SER_HI);
    assign hs      = out_vld && out_rdy;
    assign pop     = hs && sel;

    // The low coefficient never carries last; the entry's last flag rides on the high half.
    assign out_dat = !out_vld ? '0 :
                     sel      ? fifo_rd[2*pOUT_WIDTH-1:pOUT_WIDTH] :
                                fifo_rd[pOUT_WIDTH-1:0];
    assign out_lst = out_vld && sel && fifo_rd[pDATA_WIDTH];

    // A last marker off the final index, or reaching the final index without one, is a length fault.
    assign len_bad = hs && (out_lst ? (coef_cnt != LAST_IDX) : (coef_cnt == LAST_IDX));

    kernel_sfifo #(
        .pWIDTH (pDATA_WIDTH + 1),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat ({sw_lst, sw_dat}),
        .pop    (pop),
        .rd_dat (fifo_rd),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    // Serialiser: walks low then high half of the head entry, idling when nothing is buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SER_IDLE;
        end else begin
            case (state)
                SER_IDLE: if (push) state <= SER_LO;
                SER_LO:   if (hs)   state <= SER_HI;
                SER_HI: begin
                    if (hs) begin
                        // After this pop something remains if more than one entry was held or one arrives now.
                        if ((fifo_cnt > CNTW'(1)) || push) state <= SER_LO;
                        else                               state <= SER_IDLE;
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    // Coefficient index within the polynomial; restarts after last or after a missing last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_cnt <= '0;
        end else if (hs) begin
            if (out_lst || (coef_cnt == LAST_IDX)) coef_cnt <= '0;
            else                                   coef_cnt <= coef_cnt + CW'(1);
        end
    end

    // Sticky length error; a new fault outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_len <= 1'b0;
        end else if (len_bad) begin
            err_len <= 1'b1;
        end else if (clr_err) begin
            err_len <= 1'b0;
        end
    end

endmodule
